// File: rtl/hcsr04_echo_model.sv
// HC-SR04 responder emulator: accepts a trigger pulse, waits a fixed burst delay,
// then drives an echo pulse whose width encodes the programmed distance.
module hcsr04_echo_model #(
  parameter int unsigned CLKS_PER_US   = 100,
  parameter int unsigned MIN_TRIG_US   = 10,
  parameter int unsigned ECHO_DELAY_US = 500,
  parameter int unsigned US_PER_CM     = 58,
  parameter int unsigned MAX_DIST_CM   = 400,
  parameter int unsigned TIMEOUT_US    = 38000,
  parameter int unsigned HOLDOFF_US    = 10000
) (
  input  logic        clk,
  input  logic        reset_p,
  input  logic        trigger,
  input  logic [8:0]  distance_cm,
  output logic        echo,
  output logic        busy,
  output logic        trig_err,
  output logic [15:0] last_width_us,
  output logic [7:0]  meas_cnt
);

  localparam int unsigned PreW = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
  localparam logic [PreW-1:0] PreMax    = PreW'(CLKS_PER_US - 1);
  localparam logic [15:0]     MinTrig   = 16'(MIN_TRIG_US);
  localparam logic [15:0]     EchoDelay = 16'(ECHO_DELAY_US);
  localparam logic [15:0]     UsPerCm   = 16'(US_PER_CM);
  localparam logic [15:0]     Timeout   = 16'(TIMEOUT_US);
  localparam logic [15:0]     Holdoff   = 16'(HOLDOFF_US);
  localparam logic [8:0]      MaxDist   = 9'(MAX_DIST_CM);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_TRIG  = 3'd1;
  localparam logic [2:0] S_BURST = 3'd2;
  localparam logic [2:0] S_ECHO  = 3'd3;
  localparam logic [2:0] S_HOLD  = 3'd4;

  logic            trig_meta_q, trig_s_q, trig_s_dly_q;
  logic [2:0]      state_q, state_d;
  logic [PreW-1:0] pre_q, pre_d;
  logic [15:0]     us_q, us_d, us_inc;
  logic [15:0]     width_q, width_d, width_calc;
  logic            echo_q, echo_d;
  logic            busy_q;
  logic            trig_err_q, trig_err_d;
  logic [15:0]     last_q, last_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            tick, trig_rise, trig_fall, state_entry;

  assign trig_rise = trig_s_q & ~trig_s_dly_q;
  assign trig_fall = ~trig_s_q & trig_s_dly_q;
  assign tick      = (pre_q == PreMax);
  // Saturate so a stuck-high trigger cannot wrap the count and look short.
  assign us_inc    = (tick && us_q != 16'hFFFF) ? us_q + 16'd1 : us_q;

  // Out-of-range or zero distance reports the no-object timeout width.
  assign width_calc = (distance_cm == 9'd0 || distance_cm > MaxDist) ? Timeout
                                                                     : 16'(distance_cm) * UsPerCm;

  // Measurement FSM next-state and output updates.
  always_comb begin
    state_d    = state_q;
    width_d    = width_q;
    echo_d     = echo_q;
    trig_err_d = 1'b0;
    last_d     = last_q;
    cnt_d      = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (trig_rise) state_d = S_TRIG;
      end
      S_TRIG: begin
        if (trig_fall) begin
          // us_inc includes the tick of this edge, so exactly MIN_TRIG_US is accepted.
          if (us_inc >= MinTrig) begin
            width_d = width_calc;
            state_d = S_BURST;
          end else begin
            trig_err_d = 1'b1;
            state_d    = S_IDLE;
          end
        end
      end
      S_BURST: begin
        if (us_inc == EchoDelay) begin
          state_d = S_ECHO;
          echo_d  = 1'b1;
        end
      end
      S_ECHO: begin
        if (us_inc == width_q) begin
          state_d = S_HOLD;
          echo_d  = 1'b0;
          cnt_d   = cnt_q + 8'd1;
          last_d  = width_q;
        end
      end
      S_HOLD: begin
        if (us_inc == Holdoff) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Timebase restarts on every state entry so each phase is an exact multiple of 1 us.
  always_comb begin
    state_entry = (state_d != state_q);
    pre_d       = (state_entry || tick) ? '0 : pre_q + 1'b1;
    us_d        = state_entry ? 16'd0 : us_inc;
  end

  // Trigger synchronizer and edge-detect delay stage.
  always_ff @(posedge clk) begin
    if (reset_p) begin
      trig_meta_q  <= 1'b0;
      trig_s_q     <= 1'b0;
      trig_s_dly_q <= 1'b0;
    end else begin
      trig_meta_q  <= trigger;
      trig_s_q     <= trig_meta_q;
      trig_s_dly_q <= trig_s_q;
    end
  end

  // State, timebase and registered outputs.
  always_ff @(posedge clk) begin
    if (reset_p) begin
      state_q    <= S_IDLE;
      pre_q      <= '0;
      us_q       <= 16'd0;
      width_q    <= 16'd0;
      echo_q     <= 1'b0;
      busy_q     <= 1'b0;
      trig_err_q <= 1'b0;
      last_q     <= 16'd0;
      cnt_q      <= 8'd0;
    end else begin
      state_q    <= state_d;
      pre_q      <= pre_d;
      us_q       <= us_d;
      width_q    <= width_d;
      echo_q     <= echo_d;
      busy_q     <= (state_d != S_IDLE);
      trig_err_q <= trig_err_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
    end
  end

  assign echo          = echo_q;
  assign busy          = busy_q;
  assign trig_err      = trig_err_q;
  assign last_width_us = last_q;
  assign meas_cnt      = cnt_q;

endmodule
